// File: rtl/pwm_multi_channel_if.sv
// Command channel from the SPI-fed FIFO into the PWM block.
// A word transfers on a rising clk edge where cmd_valid & cmd_ready; cmd_ready never looks at cmd_valid.
interface pwm_multi_channel_if #(
  parameter int CMD_W = 19
);
  logic [CMD_W-1:0] cmd_data;
  logic             cmd_valid;
  logic             cmd_ready;

  modport master (output cmd_data, output cmd_valid, input  cmd_ready);
  modport slave  (input  cmd_data, input  cmd_valid, output cmd_ready);
endinterface

// File: rtl/pwm_multi_channel.sv
// N independent PWM channels configured through shadow registers that are
// applied only at each channel's period boundary, so outputs never see a runt pulse.
module pwm_multi_channel #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int CH_W   = 2
) (
  input  logic                clk,
  input  logic                rst,
  pwm_multi_channel_if.slave  cmd,
  output logic [NUM_CH-1:0]   pwm_out,
  output logic [NUM_CH-1:0]   period_start,
  output logic [NUM_CH-1:0]   pending,
  output logic                cmd_err
);

  localparam int CMD_W = 1 + CH_W + 2*CNT_W;

  logic [CMD_W-1:0] cmd_word;
  logic             cmd_pol;
  logic [CH_W-1:0]  cmd_ch;
  logic [CNT_W-1:0] cmd_duty;
  logic [CNT_W-1:0] cmd_per;
  logic             ch_ok;
  logic             ch_busy;
  logic             accept;

  assign cmd_word = cmd.cmd_data;
  assign {cmd_pol, cmd_ch, cmd_duty, cmd_per} = cmd_word;

  // Out-of-range channels are always ready so the FIFO drains them.
  always_comb begin
    ch_ok   = 1'b0;
    ch_busy = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cmd_ch == CH_W'(i)) begin
        ch_ok   = 1'b1;
        ch_busy = pending[i];
      end
    end
  end

  assign cmd.cmd_ready = ~ch_busy;
  assign accept        = cmd.cmd_valid & ~ch_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_err <= 1'b0;
    end else begin
      cmd_err <= accept & ~ch_ok;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, per_q, duty_q, sh_per_q, sh_duty_q;
    logic [CNT_W-1:0] cnt_d, per_d, duty_d;
    logic             pol_q, sh_pol_q, pend_q, pwm_q, ps_q;
    logic             pol_d, pend_d;
    logic             load, at_end, apply, en_d;

    assign load   = accept & ch_ok & (cmd_ch == CH_W'(g));
    assign at_end = (cnt_q == per_q - CNT_W'(1));
    // A disabled channel has no boundary to wait for, so it applies at once.
    assign apply  = pend_q & ((per_q == '0) | at_end);

    always_comb begin
      cnt_d  = cnt_q;
      per_d  = per_q;
      duty_d = duty_q;
      pol_d  = pol_q;
      pend_d = pend_q;
      if (apply) begin
        per_d  = sh_per_q;
        duty_d = sh_duty_q;
        pol_d  = sh_pol_q;
        cnt_d  = '0;
        pend_d = 1'b0;
      end else if (per_q != '0) begin
        cnt_d = at_end ? '0 : cnt_q + CNT_W'(1);
      end else begin
        cnt_d = '0;
      end
      // load needs pend_q low and apply needs it high, so they never collide.
      if (load) pend_d = 1'b1;
    end

    assign en_d = (per_d != '0);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q     <= '0;
        per_q     <= '0;
        duty_q    <= '0;
        pol_q     <= 1'b0;
        sh_per_q  <= '0;
        sh_duty_q <= '0;
        sh_pol_q  <= 1'b0;
        pend_q    <= 1'b0;
        pwm_q     <= 1'b0;
        ps_q      <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        per_q  <= per_d;
        duty_q <= duty_d;
        pol_q  <= pol_d;
        pend_q <= pend_d;
        if (load) begin
          sh_pol_q  <= cmd_pol;
          sh_duty_q <= cmd_duty;
          sh_per_q  <= cmd_per;
        end
        // Outputs are computed from next-state values so they line up with cnt_q.
        pwm_q <= en_d ? ((cnt_d < duty_d) ^ pol_d) : pol_d;
        ps_q  <= en_d & (cnt_d == '0);
      end
    end

    assign pwm_out[g]      = pwm_q;
    assign period_start[g] = ps_q;
    assign pending[g]      = pend_q;
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed bench for pwm_multi_channel: a 4-channel instance plus a 3-channel
// instance for the out-of-range channel case.
module tb_pwm_multi_channel;

  localparam int CMD_W = 19;

  logic clk;
  logic rst;
  logic [3:0] pwm_out, period_start, pending;
  logic       cmd_err;
  logic [2:0] pwm3, ps3, pend3;
  logic       err3;

  int checks   = 0;
  int failures = 0;

  pwm_multi_channel_if #(.CMD_W(CMD_W)) cif ();
  pwm_multi_channel_if #(.CMD_W(CMD_W)) cif3 ();

  pwm_multi_channel #(.NUM_CH(4), .CNT_W(8), .CH_W(2)) dut (
    .clk(clk), .rst(rst), .cmd(cif.slave),
    .pwm_out(pwm_out), .period_start(period_start), .pending(pending), .cmd_err(cmd_err)
  );

  pwm_multi_channel #(.NUM_CH(3), .CNT_W(8), .CH_W(2)) dut3 (
    .clk(clk), .rst(rst), .cmd(cif3.slave),
    .pwm_out(pwm3), .period_start(ps3), .pending(pend3), .cmd_err(err3)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [CMD_W-1:0] mk(input logic pol, input logic [1:0] ch,
                                          input logic [7:0] duty, input logic [7:0] per);
    return {pol, ch, duty, per};
  endfunction

  // driver: present a word, wait for ready, let one edge take it
  task automatic send(input logic [CMD_W-1:0] w, input string tag);
    int n;
    n = 0;
    cif.cmd_data  = w;
    cif.cmd_valid = 1'b1;
    #1;
    while (!cif.cmd_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 32'(cif.cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
  endtask

  // expected waveform: counter value c -> pwm=(c<duty)^pol, period_start=(c==0)
  task automatic run_chk(input int ch, input int k0, input int n, input int duty,
                         input int per, input logic pol, input string tag);
    int c;
    for (int k = 0; k < n; k++) begin
      c = (k0 + k) % per;
      check({tag, "_pwm"}, 32'(pwm_out[ch]), 32'((c < duty) ? 1 : 0) ^ 32'(pol));
      check({tag, "_ps"}, 32'(period_start[ch]), 32'((c == 0) ? 1 : 0));
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    rst            = 1'b0;
    cif.cmd_valid  = 1'b0;
    cif.cmd_data   = '0;
    cif3.cmd_valid = 1'b0;
    cif3.cmd_data  = '0;
    repeat (2) @(negedge clk);

    check("rst_pwm",     32'(pwm_out),      32'd0);
    check("rst_ps",      32'(period_start), 32'd0);
    check("rst_pending", 32'(pending),      32'd0);
    check("rst_err",     32'(cmd_err),      32'd0);
    check("rst_ready",   32'(cif.cmd_ready), 32'd1);
    rst = 1'b1;
    @(negedge clk);

    // 1: ch0 10/30 from disabled
    send(mk(1'b0, 2'd0, 8'd10, 8'd30), "t1");
    check("t1_pend_set", 32'(pending[0]), 32'd1);
    check("t1_pwm_idle", 32'(pwm_out[0]), 32'd0);
    @(negedge clk);
    check("t1_pend_clr", 32'(pending[0]), 32'd0);
    run_chk(0, 0, 45, 10, 30, 1'b0, "t1");

    // 2: mid-period rewrite to duty 20 / period 10, applied at the 30-cycle boundary
    send(mk(1'b0, 2'd0, 8'd20, 8'd10), "t2");
    check("t2_pend_hold", 32'(pending[0]), 32'd1);
    cif.cmd_data = mk(1'b0, 2'd0, 8'd1, 8'd1);
    #1;
    check("t2_ready_busy", 32'(cif.cmd_ready), 32'd0);
    run_chk(0, 16, 14, 10, 30, 1'b0, "t2_old");
    check("t2_pend_clr", 32'(pending[0]), 32'd0);
    run_chk(0, 0, 25, 20, 10, 1'b0, "t2_new");

    // 3: back-to-back on ch1 with other channels slipping in while it stalls
    cif.cmd_data  = mk(1'b0, 2'd1, 8'd3, 8'd8);
    cif.cmd_valid = 1'b1;
    #1;
    check("t3_a_ready", 32'(cif.cmd_ready), 32'd1);
    @(negedge clk);
    check("t3_a_pend", 32'(pending[1]), 32'd1);
    cif.cmd_data = mk(1'b0, 2'd1, 8'd2, 8'd8);
    #1;
    check("t3_b_stall", 32'(cif.cmd_ready), 32'd0);
    @(negedge clk);
    check("t3_a_applied", 32'(pending[1]), 32'd0);
    check("t3_b_ready", 32'(cif.cmd_ready), 32'd1);
    @(negedge clk);
    check("t3_b_pend", 32'(pending[1]), 32'd1);
    cif.cmd_data = mk(1'b0, 2'd2, 8'd0, 8'd0);
    #1;
    check("t3_ch2_ready", 32'(cif.cmd_ready), 32'd1);
    @(negedge clk);
    check("t3_ch2_pend", 32'(pending[2]), 32'd1);
    check("t3_ch1_pend", 32'(pending[1]), 32'd1);
    cif.cmd_data = mk(1'b0, 2'd3, 8'd0, 8'd0);
    #1;
    check("t3_ch3_ready", 32'(cif.cmd_ready), 32'd1);
    @(negedge clk);
    check("t3_ch3_pend", 32'(pending[3]), 32'd1);
    check("t3_ch2_done", 32'(pending[2]), 32'd0);
    cif.cmd_data = mk(1'b0, 2'd1, 8'd6, 8'd8);
    #1;
    check("t3_c_stall", 32'(cif.cmd_ready), 32'd0);
    n = 0;
    while (!cif.cmd_ready && n < 32) begin
      @(negedge clk);
      n++;
    end
    check("t3_stall_len", 32'(n), 32'd5);
    check("t3_b_applied", 32'(pending[1]), 32'd0);
    @(negedge clk);
    check("t3_c_pend", 32'(pending[1]), 32'd1);
    cif.cmd_valid = 1'b0;

    // 4: ch3 inverted 5/8, then period 0 disables it at the boundary
    send(mk(1'b1, 2'd3, 8'd5, 8'd8), "t4");
    check("t4_pend", 32'(pending[3]), 32'd1);
    check("t4_pwm_idle", 32'(pwm_out[3]), 32'd0);
    @(negedge clk);
    run_chk(3, 0, 16, 5, 8, 1'b1, "t4");
    send(mk(1'b1, 2'd3, 8'd5, 8'd0), "t4d");
    check("t4d_pend", 32'(pending[3]), 32'd1);
    run_chk(3, 1, 7, 5, 8, 1'b1, "t4_tail");
    check("t4d_pend_clr", 32'(pending[3]), 32'd0);
    for (int k = 0; k < 10; k++) begin
      check("t4d_pwm", 32'(pwm_out[3]), 32'd1);
      check("t4d_ps", 32'(period_start[3]), 32'd0);
      @(negedge clk);
    end

    // 5: out-of-range channel on the 3-channel instance
    cif3.cmd_data  = mk(1'b0, 2'd3, 8'd5, 8'd8);
    cif3.cmd_valid = 1'b1;
    #1;
    check("t5_ready", 32'(cif3.cmd_ready), 32'd1);
    @(negedge clk);
    cif3.cmd_valid = 1'b0;
    check("t5_err", 32'(err3), 32'd1);
    check("t5_pend", 32'(pend3), 32'd0);
    check("t5_pwm", 32'(pwm3), 32'd0);
    check("t5_ps", 32'(ps3), 32'd0);
    check("t5_main_err", 32'(cmd_err), 32'd0);
    @(negedge clk);
    check("t5_err_pulse", 32'(err3), 32'd0);

    // 6: async reset with ch0 pending, then everything stays idle
    send(mk(1'b0, 2'd0, 8'd3, 8'd10), "t6");
    check("t6_pend", 32'(pending[0]), 32'd1);
    #3;
    rst = 1'b0;
    #1;
    check("t6_rst_pwm",  32'(pwm_out),      32'd0);
    check("t6_rst_ps",   32'(period_start), 32'd0);
    check("t6_rst_pend", 32'(pending),      32'd0);
    check("t6_rst_err",  32'(cmd_err),      32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("t6_idle_pwm", 32'(pwm_out), 32'd0);
      check("t6_idle_ps", 32'(period_start), 32'd0);
      check("t6_idle_pend", 32'(pending), 32'd0);
    end
    send(mk(1'b0, 2'd2, 8'd1, 8'd2), "t6n");
    @(negedge clk);
    run_chk(2, 0, 6, 1, 2, 1'b0, "t6n");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
